// File: rtl/mae_dot_acc.sv
// Streaming saturating dot-product accumulator behind the MAE multiplier.
// Sums LEN signed products (or fewer, ended by P_LAST) and hands each result out on a valid/ready port.
module mae_dot_acc #(
    parameter int P_WIDTH   = 40,
    parameter int ACC_WIDTH = 48,
    parameter int LEN       = 16,
    parameter bit SATURATE  = 1'b1
) (
    input  logic                 CLK,
    input  logic                 ARST_N,
    input  logic                 SRST_N,
    input  logic [P_WIDTH-1:0]   P,
    input  logic                 P_VALID,
    input  logic                 P_LAST,
    output logic                 P_READY,
    output logic [ACC_WIDTH-1:0] ACC,
    output logic                 ACC_OVF,
    output logic                 ACC_VALID,
    input  logic                 ACC_READY
);

    localparam logic [15:0] LAST_CNT = 16'(LEN - 1);

    logic [15:0]          cnt;
    logic [ACC_WIDTH-1:0] acc;
    logic                 ovf;

    logic                 accept;
    logic                 term_end;
    logic                 first_term;
    logic                 sum_ovf;
    logic                 next_ovf;
    logic [ACC_WIDTH:0]   p_ext;
    logic [ACC_WIDTH:0]   sum;
    logic [ACC_WIDTH-1:0] sat_val;
    logic [ACC_WIDTH-1:0] next_acc;

    // Ready depends only on the output handshake so the upstream path stays short.
    assign P_READY    = ~ACC_VALID | ACC_READY;
    assign accept     = P_VALID & P_READY;
    assign first_term = (cnt == '0);
    assign term_end   = (cnt == LAST_CNT) | P_LAST;

    assign p_ext   = {{(ACC_WIDTH - P_WIDTH + 1){P[P_WIDTH-1]}}, P};
    assign sum     = {acc[ACC_WIDTH-1], acc} + p_ext;
    assign sum_ovf = ~first_term & (sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1]);
    assign sat_val = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                    : {1'b0, {(ACC_WIDTH-1){1'b1}}};

    always_comb begin
        next_acc = sum[ACC_WIDTH-1:0];
        if (first_term) begin
            next_acc = p_ext[ACC_WIDTH-1:0];
        end else if (sum_ovf && SATURATE) begin
            next_acc = sat_val;
        end
        next_ovf = ~first_term & (ovf | sum_ovf);
    end

    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            cnt       <= '0;
            acc       <= '0;
            ovf       <= 1'b0;
            ACC       <= '0;
            ACC_OVF   <= 1'b0;
            ACC_VALID <= 1'b0;
        end else if (!SRST_N) begin
            cnt       <= '0;
            acc       <= '0;
            ovf       <= 1'b0;
            ACC       <= '0;
            ACC_OVF   <= 1'b0;
            ACC_VALID <= 1'b0;
        end else begin
            if (accept) begin
                acc <= next_acc;
                ovf <= next_ovf;
                if (term_end) begin
                    cnt     <= '0;
                    ACC     <= next_acc;
                    ACC_OVF <= next_ovf;
                end else begin
                    cnt <= cnt + 16'd1;
                end
            end
            // A new result landing in the same cycle as a consume keeps valid high.
            if (accept && term_end) begin
                ACC_VALID <= 1'b1;
            end else if (ACC_READY) begin
                ACC_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mae_dot_acc.sv
// Bench for mae_dot_acc: five parameterisations share one input stream and are
// compared each cycle against a group-level arithmetic model.
module tb_mae_dot_acc;

    localparam int NI = 5;
    localparam int AWS  [NI] = '{48, 48, 41, 41, 48};
    localparam int LENS [NI] = '{16, 4, 4, 4, 1};
    localparam bit SATS [NI] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    logic        CLK;
    logic        ARST_N;
    logic        SRST_N;
    logic [39:0] P;
    logic        P_VALID;
    logic        P_LAST;
    logic        ACC_READY;

    logic signed [63:0] acc_obs   [NI];
    logic               ovf_obs   [NI];
    logic               valid_obs [NI];
    logic               ready_obs [NI];

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: pending products per instance plus the visible result.
    longint grp     [NI][$];
    longint e_acc   [NI];
    bit     e_ovf   [NI];
    bit     e_valid [NI];

    genvar g;
    for (g = 0; g < NI; g++) begin : g_dut
        logic signed [AWS[g]-1:0] acc_w;
        logic ovf_w, valid_w, ready_w;

        mae_dot_acc #(
            .P_WIDTH  (40),
            .ACC_WIDTH(AWS[g]),
            .LEN      (LENS[g]),
            .SATURATE (SATS[g])
        ) u_dut (
            .CLK      (CLK),
            .ARST_N   (ARST_N),
            .SRST_N   (SRST_N),
            .P        (P),
            .P_VALID  (P_VALID),
            .P_LAST   (P_LAST),
            .P_READY  (ready_w),
            .ACC      (acc_w),
            .ACC_OVF  (ovf_w),
            .ACC_VALID(valid_w),
            .ACC_READY(ACC_READY)
        );

        assign acc_obs[g]   = 64'(acc_w);
        assign ovf_obs[g]   = ovf_w;
        assign valid_obs[g] = valid_w;
        assign ready_obs[g] = ready_w;
    end

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic checkOutput(input string tag, input int idx, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s[%0d] got=%0d expected=%0d at %0t", tag, idx, obs, exp, $time);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < NI; i++) begin
            grp[i].delete();
            e_acc[i]   = 0;
            e_ovf[i]   = 1'b0;
            e_valid[i] = 1'b0;
        end
    endtask

    // Fold a finished group with ordinary integer arithmetic, clamping or wrapping at AW bits.
    task automatic foldGroup(input int i, output longint res, output bit ov);
        longint mx, mn, s;
        mx  = (longint'(1) << (AWS[i] - 1)) - 1;
        mn  = -(longint'(1) << (AWS[i] - 1));
        res = grp[i][0];
        ov  = 1'b0;
        for (int k = 1; k < grp[i].size(); k++) begin
            s = res + grp[i][k];
            if (s > mx || s < mn) begin
                ov = 1'b1;
                if (SATS[i]) s = (s > mx) ? mx : mn;
                else         s = (s > mx) ? s - (longint'(1) << AWS[i]) : s + (longint'(1) << AWS[i]);
            end
            res = s;
        end
    endtask

    task automatic checkState(input string tag);
        for (int i = 0; i < NI; i++) begin
            checkOutput({tag, "_valid"}, i, longint'(valid_obs[i]), longint'(e_valid[i]));
            checkOutput({tag, "_acc"},   i, acc_obs[i], e_acc[i]);
            checkOutput({tag, "_ovf"},   i, longint'(ovf_obs[i]), longint'(e_ovf[i]));
        end
    endtask

    // One full clock cycle: drive at the falling edge, check ready, step the model, check results.
    task automatic applyStimulus(input longint p, input bit pv, input bit pl, input bit ar, input bit srst_n);
        bit     take [NI];
        longint res;
        bit     ov;
        P         = p[39:0];
        P_VALID   = pv;
        P_LAST    = pl;
        ACC_READY = ar;
        SRST_N    = srst_n;
        #1;
        for (int i = 0; i < NI; i++) begin
            checkOutput("p_ready", i, longint'(ready_obs[i]), longint'(!e_valid[i] || ar));
            take[i] = pv && (!e_valid[i] || ar);
        end
        @(posedge CLK);
        if (!srst_n) begin
            clearModel();
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (take[i]) begin
                    grp[i].push_back(p);
                    if (grp[i].size() == LENS[i] || pl) begin
                        foldGroup(i, res, ov);
                        grp[i].delete();
                        e_acc[i]   = res;
                        e_ovf[i]   = ov;
                        e_valid[i] = 1'b1;
                    end else if (ar) begin
                        e_valid[i] = 1'b0;
                    end
                end else if (ar) begin
                    e_valid[i] = 1'b0;
                end
            end
        end
        @(negedge CLK);
        checkState("cyc");
    endtask

    task automatic feed(input longint p);
        applyStimulus(p, 1'b1, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic asyncPulse();
        P_VALID = 1'b0;
        #2 ARST_N = 1'b0;
        #1;
        clearModel();
        for (int i = 0; i < NI; i++) begin
            checkOutput("arst_valid", i, longint'(valid_obs[i]), 0);
            checkOutput("arst_acc",   i, acc_obs[i], 0);
            checkOutput("arst_ovf",   i, longint'(ovf_obs[i]), 0);
        end
        #1 ARST_N = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        longint pmax, pmin, p;
        logic signed [39:0] t;
        pmax = (longint'(1) << 39) - 1;
        pmin = -(longint'(1) << 39);

        ARST_N = 1'b0; SRST_N = 1'b1; P = '0; P_VALID = 1'b0; P_LAST = 1'b0; ACC_READY = 1'b0;
        clearModel();
        repeat (2) @(negedge CLK);
        checkState("reset");
        ARST_N = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) checkOutput("reset_ready", i, longint'(ready_obs[i]), 1);
        @(negedge CLK);

        // Basic LEN=4 group, then the result must be gone after one cycle.
        feed(1000); feed(2000); feed(-500); feed(7);
        checkOutput("basic_acc",   1, acc_obs[1], 2507);
        checkOutput("basic_valid", 1, longint'(valid_obs[1]), 1);
        checkOutput("basic_ovf",   1, longint'(ovf_obs[1]), 0);
        applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("basic_pulse", 1, longint'(valid_obs[1]), 0);

        // Early end followed by a full group.
        feed(5); applyStimulus(6, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("early_acc", 1, acc_obs[1], 11);
        feed(1); feed(1); feed(1); feed(1);
        checkOutput("b2b_acc",   1, acc_obs[1], 4);
        checkOutput("b2b_valid", 1, longint'(valid_obs[1]), 1);

        // Saturation and wrap on the 41-bit instances.
        feed(pmax); feed(pmax); feed(pmax); feed(pmax);
        checkOutput("sat_acc", 2, acc_obs[2], (longint'(1) << 40) - 1);
        checkOutput("sat_ovf", 2, longint'(ovf_obs[2]), 1);
        feed(1); feed(1); feed(1); feed(1);
        checkOutput("sat_next_acc", 2, acc_obs[2], 4);
        checkOutput("sat_next_ovf", 2, longint'(ovf_obs[2]), 0);
        feed(pmin); feed(pmin); feed(pmin); feed(pmin);
        checkOutput("wrap_acc", 3, acc_obs[3], 0);
        checkOutput("wrap_ovf", 3, longint'(ovf_obs[3]), 1);

        // Backpressure holds the pending result and blocks new products.
        feed(3); feed(3); feed(3); feed(3);
        applyStimulus(100, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(100, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("bp_ready", 1, longint'(ready_obs[1]), 0);
        checkOutput("bp_acc",   1, acc_obs[1], 12);
        feed(2); feed(2); feed(2); feed(2);
        checkOutput("bp_after_acc", 1, acc_obs[1], 8);

        // Synchronous clear mid-group overrides a concurrent product.
        feed(10); feed(20);
        applyStimulus(99, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("srst_acc",   1, acc_obs[1], 0);
        checkOutput("srst_valid", 1, longint'(valid_obs[1]), 0);
        feed(1); feed(2); feed(3); feed(4);
        checkOutput("srst_after_acc", 1, acc_obs[1], 10);

        // Asynchronous clear mid-group.
        feed(10); feed(20);
        asyncPulse();
        feed(1); feed(2); feed(3); feed(4);
        checkOutput("arst_after_acc", 1, acc_obs[1], 10);

        // Randomised traffic with gaps, early ends, backpressure and rare clears.
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 3))
                0: p = longint'($urandom_range(0, 2000)) - 1000;
                1: begin t = 40'({$urandom, $urandom}); p = t; end
                2: p = pmax - longint'($urandom_range(0, 3));
                default: p = pmin + longint'($urandom_range(0, 3));
            endcase
            applyStimulus(p, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                          $urandom_range(0, 9) < 7, $urandom_range(0, 99) >= 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
